// File: rtl/timer_display_sample_reader.sv
// Avalon-MM read master: streams 32-bit words from the sample RAM out as 16-bit
// samples, low half first. Outstanding reads are credit-limited against the word FIFO.
module timer_display_sample_reader #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_PEND   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic [ADDR_W-1:0] ctrl_base,
  input  logic [ADDR_W:0]   ctrl_len,
  input  logic              ctrl_loop,
  output logic              status_busy,
  output logic              status_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [15:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                loop_q, loop_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                stall_q, stall_d;
  logic                done_q, done_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                half_q, half_d;
  logic [31:0]         mem_q [FIFO_DEPTH];

  logic credit_ok;
  logic issue;
  logic ret;
  logic push;
  logic take;
  logic pop;

  // Words in flight plus words buffered may never exceed the FIFO depth.
  assign credit_ok = ((32'(pend_q) + 32'(cnt_q)) < FIFO_DEPTH) && (32'(pend_q) < MAX_PEND);

  // In STOP only a request already stalled by waitrequest is kept asserted.
  assign avm_read = ((state_q == S_FETCH) && (rem_q != '0) && credit_ok) ||
                    ((state_q == S_STOP) && stall_q);

  assign issue = avm_read && !avm_waitrequest;
  assign ret   = avm_readdatavalid && (pend_q != '0);
  assign push  = ret && ((state_q == S_FETCH) || (state_q == S_DRAIN));
  assign take  = src_valid && src_ready;
  assign pop   = take && half_q;

  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign status_busy    = (state_q != S_IDLE);
  assign status_done    = done_q;
  assign src_valid      = (cnt_q != '0) && (state_q != S_STOP);
  assign src_data       = half_q ? mem_q[rd_ptr_q][31:16] : mem_q[rd_ptr_q][15:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    base_d  = base_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    stall_d = avm_read && avm_waitrequest;
    pend_d  = pend_q + PEND_W'(issue) - PEND_W'(ret);

    unique case (state_q)
      S_IDLE: begin
        if (ctrl_start && !ctrl_stop && (ctrl_len != '0)) begin
          state_d = S_FETCH;
          base_d  = ctrl_base;
          len_d   = ctrl_len;
          loop_d  = ctrl_loop;
          addr_d  = ctrl_base;
          rem_d   = ctrl_len;
        end
      end
      S_FETCH: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            if (loop_q) begin
              addr_d = base_q;
              rem_d  = len_q;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
        if (ctrl_stop) state_d = S_STOP;
      end
      S_DRAIN: begin
        if (ctrl_stop) begin
          state_d = S_STOP;
        end else if ((pend_q == '0) && (cnt_q == '0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_STOP: begin
        if ((pend_q == '0) && !avm_read) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    if (state_q == S_STOP) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      half_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (take) half_d = ~half_q;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      pend_q   <= '0;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      half_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      base_q   <= base_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      pend_q   <= pend_d;
      stall_q  <= stall_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= avm_readdata;
  end

endmodule

// File: tb/tb_timer_display_sample_reader.sv
// Directed bench for timer_display_sample_reader with a queue-based Avalon slave
// whose RAM holds word i = {i, i}.
module tb_timer_display_sample_reader;

  localparam int unsigned ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ctrl_start, ctrl_stop, ctrl_loop;
  logic [ADDR_W-1:0] ctrl_base;
  logic [ADDR_W:0]   ctrl_len;
  logic              status_busy, status_done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic [15:0]       src_data;
  logic              src_valid;
  logic              src_ready;

  timer_display_sample_reader #(.ADDR_W(14), .FIFO_DEPTH(8), .MAX_PEND(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_base(ctrl_base),
    .ctrl_len(ctrl_len), .ctrl_loop(ctrl_loop),
    .status_busy(status_busy), .status_done(status_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram(input logic [ADDR_W-1:0] a);
    return {2'b00, a, 2'b00, a};
  endfunction

  // Slave: accepted addresses are queued and answered one per cycle unless held.
  logic [ADDR_W-1:0] rq[$];
  bit hold_resp = 1'b0;
  bit wait_rand = 1'b0;
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) rq.push_back(avm_address);
    if (!hold_resp && rq.size() > 0) begin
      avm_readdatavalid <= 1'b1;
      avm_readdata      <= ram(rq.pop_front());
    end else begin
      avm_readdatavalid <= 1'b0;
    end
    avm_waitrequest <= wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  logic [ADDR_W-1:0] iss_q[$];
  logic [15:0]       out_q[$];
  int n_iss, n_out, max_out, n_done, done_busy_err, stab_err, n_stall, stop_valid_err;
  bit in_stop = 1'b0;
  bit stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_addr;

  always @(negedge clk) begin
    if (avm_read && !avm_waitrequest) begin
      iss_q.push_back(avm_address);
      n_iss++;
    end
    if (src_valid && src_ready) begin
      out_q.push_back(src_data);
      n_out++;
    end
    if (n_iss - n_out / 2 > max_out) max_out = n_iss - n_out / 2;
    if (stall_prev && !(avm_read && avm_address == stall_addr)) stab_err++;
    stall_prev = avm_read && avm_waitrequest && reset_n;
    stall_addr = avm_address;
    if (stall_prev) n_stall++;
    if (status_done) begin
      n_done++;
      if (status_busy) done_busy_err++;
    end
    if (in_stop && status_busy && src_valid) stop_valid_err++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    iss_q.delete();
    out_q.delete();
    n_iss = 0; n_out = 0; max_out = 0; n_done = 0;
    done_busy_err = 0; stab_err = 0; n_stall = 0; stop_valid_err = 0;
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len, input logic loop);
    ctrl_base  = base;
    ctrl_len   = len;
    ctrl_loop  = loop;
    ctrl_start = 1'b1;
    tick(1);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (status_busy && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_timeout_busy"}, 32'(status_busy), 32'd0);
    tick(2);
  endtask

  task automatic check_stream(input string tag, input logic [ADDR_W-1:0] base, input int nw);
    logic [ADDR_W-1:0] a;
    logic [31:0] w;
    check({tag, "_n_issued"}, iss_q.size(), nw);
    check({tag, "_n_samples"}, out_q.size(), 2 * nw);
    for (int i = 0; i < nw && i < iss_q.size() && 2 * i + 1 < out_q.size(); i++) begin
      a = base + ADDR_W'(i);
      w = ram(a);
      check({tag, "_addr"}, 32'(iss_q[i]), 32'(a));
      check({tag, "_lo"}, 32'(out_q[2 * i]), 32'(w[15:0]));
      check({tag, "_hi"}, 32'(out_q[2 * i + 1]), 32'(w[31:16]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    reset_n = 1'b0; ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_loop = 1'b0;
    ctrl_base = '0; ctrl_len = '0; src_ready = 1'b1;
    clear_mon();
    tick(2);
    check("rst_busy", 32'(status_busy), 0);
    check("rst_done", 32'(status_done), 0);
    check("rst_read", 32'(avm_read), 0);
    check("rst_addr", 32'(avm_address), 0);
    check("rst_valid", 32'(src_valid), 0);
    check("byteenable", 32'(avm_byteenable), 32'hF);
    reset_n = 1'b1;
    tick(2);

    // Zero-length start is ignored.
    start(14'h5, '0, 1'b0);
    tick(3);
    check("len0_busy", 32'(status_busy), 0);
    check("len0_issued", n_iss, 0);
    check("len0_done", n_done, 0);

    // Start and stop together in IDLE: stop wins.
    ctrl_stop = 1'b1;
    start(14'h5, 15'd4, 1'b0);
    ctrl_stop = 1'b0;
    tick(3);
    check("startstop_busy", 32'(status_busy), 0);
    check("startstop_issued", n_iss, 0);

    // T1: basic transfer; control inputs changed after start must not matter.
    clear_mon();
    start(14'h10, 15'd4, 1'b0);
    ctrl_base = 14'h33; ctrl_len = 15'd1; ctrl_loop = 1'b1;
    check("t1_busy", 32'(status_busy), 1);
    check("t1_first_read", 32'(avm_read), 1);
    check("t1_first_addr", 32'(avm_address), 32'h10);
    tick(1);
    check("t1_rdv", 32'(avm_readdatavalid), 1);
    check("t1_valid_before", 32'(src_valid), 0);
    tick(1);
    check("t1_valid_after", 32'(src_valid), 1);
    wait_idle("t1", 100);
    check_stream("t1", 14'h10, 4);
    check("t1_done_pulses", n_done, 1);
    check("t1_done_with_busy", done_busy_err, 0);

    // T2: backpressure fills credits exactly to the FIFO depth.
    clear_mon();
    src_ready = 1'b0;
    start(14'h100, 15'd32, 1'b0);
    tick(50);
    check("t2_issued_stalled", n_iss, 8);
    check("t2_valid_held", 32'(src_valid), 1);
    check("t2_data_held", 32'(src_data), 32'h0100);
    src_ready = 1'b1;
    wait_idle("t2", 400);
    check_stream("t2", 14'h100, 32);
    check("t2_max_outstanding", max_out, 8);
    check("t2_done_pulses", n_done, 1);

    // T3: random waitrequest.
    clear_mon();
    wait_rand = 1'b1;
    start(14'h200, 15'd20, 1'b0);
    wait_idle("t3", 1000);
    wait_rand = 1'b0;
    tick(2);
    check_stream("t3", 14'h200, 20);
    check("t3_stall_stable", stab_err, 0);
    check("t3_saw_stalls", 32'(n_stall > 0), 1);
    check("t3_done_pulses", n_done, 1);

    // T4: address wrap.
    clear_mon();
    start(14'h3FFE, 15'd4, 1'b0);
    wait_idle("t4", 100);
    check_stream("t4", 14'h3FFE, 4);

    // T5: looping transfer, then stop.
    clear_mon();
    start(14'h40, 15'd3, 1'b1);
    tick(40);
    check("t5_enough_issues", 32'(iss_q.size() >= 9), 1);
    for (int i = 0; i < 9 && i < iss_q.size(); i++)
      check("t5_loop_addr", 32'(iss_q[i]), 32'h40 + 32'(i % 3));
    for (int i = 0; i < 6 && 2 * i + 1 < out_q.size(); i++) begin
      w = ram(14'h40 + ADDR_W'(i % 3));
      check("t5_loop_lo", 32'(out_q[2 * i]), 32'(w[15:0]));
      check("t5_loop_hi", 32'(out_q[2 * i + 1]), 32'(w[31:16]));
    end
    check("t5_busy", 32'(status_busy), 1);
    ctrl_stop = 1'b1;
    tick(1);
    ctrl_stop = 1'b0;
    in_stop = 1'b1;
    wait_idle("t5", 50);
    in_stop = 1'b0;
    check("t5_valid_in_stop", stop_valid_err, 0);
    check("t5_no_done", n_done, 0);
    check("t5_read_after", 32'(avm_read), 0);
    check("t5_valid_after", 32'(src_valid), 0);

    // T6: reset with two reads outstanding.
    clear_mon();
    hold_resp = 1'b1;
    start(14'h80, 15'd8, 1'b0);
    tick(6);
    check("t6_pend_limit", n_iss, 2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_read", 32'(avm_read), 0);
    check("t6_rst_busy", 32'(status_busy), 0);
    check("t6_rst_addr", 32'(avm_address), 0);
    check("t6_rst_valid", 32'(src_valid), 0);
    tick(2);
    reset_n = 1'b1;
    hold_resp = 1'b0;
    tick(6);
    check("t6_late_samples", n_out, 0);
    check("t6_late_valid", 32'(src_valid), 0);
    check("t6_late_busy", 32'(status_busy), 0);
    clear_mon();
    start(14'h20, 15'd2, 1'b0);
    wait_idle("t6b", 100);
    check_stream("t6b", 14'h20, 2);
    check("t6b_done_pulses", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
